// File: rtl/calc_mailbox_pkg.sv
// Shared definitions for the calculator mailbox: FSM states, register map
// offsets, one-hot opcode values and STATUS bit positions.
package calc_mailbox_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Byte offsets from BASE_ADDR
    localparam logic [31:0] OFF_OPA    = 32'd0;
    localparam logic [31:0] OFF_OPB    = 32'd4;
    localparam logic [31:0] OFF_OPCODE = 32'd8;
    localparam logic [31:0] OFF_STATUS = 32'd12;
    localparam logic [31:0] OFF_RESULT = 32'd16;
    localparam logic [31:0] OFF_CTRL   = 32'd20;
    localparam logic [31:0] OFF_DUMP   = 32'd24;

    // One-hot opcodes
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0001;

    // STATUS bit positions
    localparam int unsigned ST_BUSY     = 0;
    localparam int unsigned ST_DONE     = 1;
    localparam int unsigned ST_TIMEOUT  = 2;
    localparam int unsigned ST_OVERRUN  = 3;
    localparam int unsigned ST_BAD_OP   = 4;
    localparam int unsigned ST_MASK_LSB = 5;

    // Written-mask bit positions inside the 3-bit mask {OPCODE, OPB, OPA}
    localparam int unsigned MASK_OPA    = 0;
    localparam int unsigned MASK_OPB    = 1;
    localparam int unsigned MASK_OPCODE = 2;

    function automatic logic opcode_valid(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/calc_mailbox_timer.sv
// RUN-state watchdog for calc_mailbox. Only compiled when
// CALC_MAILBOX_TIMEOUT_EN is defined; expired_o is high on the last
// allowed RUN cycle (counter at TIMEOUT_CYCLES-1).
`ifdef CALC_MAILBOX_TIMEOUT_EN
module calc_mailbox_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count cycles spent in RUN; restart from zero whenever RUN is left
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/calc_mailbox.sv
// CPU-side mailbox for the calculator front-end: captures operands/opcode
// from the front-end, exposes them on a CPU load/store port, sequences the
// run/done handshake and returns the CPU result for display.
// Optional RUN watchdog: define CALC_MAILBOX_TIMEOUT_EN.
module calc_mailbox
    import calc_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'd220,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [31:0] fpga_addr,
    input  logic [31:0] fpga_wdata,
    input  logic        fpga_we,
    input  logic        fpga_start,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_run,
    output logic [31:0] result,
    output logic        result_valid
);

    localparam logic [31:0] A_OPA    = BASE_ADDR + OFF_OPA;
    localparam logic [31:0] A_OPB    = BASE_ADDR + OFF_OPB;
    localparam logic [31:0] A_OPCODE = BASE_ADDR + OFF_OPCODE;
    localparam logic [31:0] A_STATUS = BASE_ADDR + OFF_STATUS;
    localparam logic [31:0] A_RESULT = BASE_ADDR + OFF_RESULT;
    localparam logic [31:0] A_CTRL   = BASE_ADDR + OFF_CTRL;
    localparam logic [31:0] A_DUMP   = BASE_ADDR + OFF_DUMP;

    state_e      state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [2:0]  mask_q, mask_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;
    logic [31:0] result_q, result_d;
    logic        start_q;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;

    logic        hit_opa, hit_opb, hit_opcode, fpga_op_wr;
    logic        wr_result, wr_ctrl, done_req, clr_sticky;
    logic        start_rise, accept_ops;
    logic        clear_mask, enter_run, set_timeout;
    logic        timer_expired;
    logic [31:0] status;

    assign hit_opa    = fpga_we && (fpga_addr == A_OPA);
    assign hit_opb    = fpga_we && (fpga_addr == A_OPB);
    assign hit_opcode = fpga_we && (fpga_addr == A_OPCODE);
    assign fpga_op_wr = hit_opa || hit_opb || hit_opcode;

    assign wr_result  = cpu_we && (cpu_addr == A_RESULT);
    assign wr_ctrl    = cpu_we && (cpu_addr == A_CTRL);
    assign done_req   = wr_ctrl && cpu_wdata[0];
    assign clr_sticky = wr_ctrl && cpu_wdata[1];

    assign start_rise = fpga_start && !start_q;
    assign accept_ops = (state_q == IDLE) || (state_q == ARMED);

`ifdef CALC_MAILBOX_TIMEOUT_EN
    calc_mailbox_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (hz100),
        .rst_ni    (reset),
        .run_i     (state_q == RUN),
        .expired_o (timer_expired)
    );
`else
    // No watchdog in this build; RUN waits for the CPU indefinitely
    assign timer_expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // Handshake FSM next-state logic
    always_comb begin
        state_d     = state_q;
        clear_mask  = 1'b0;
        enter_run   = 1'b0;
        set_timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (&mask_q) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (start_rise) begin
                    state_d   = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                if (done_req) begin
                    state_d = DONE;
                end else if (timer_expired) begin
                    state_d     = DONE;
                    set_timeout = 1'b1;
                end
            end
            DONE: begin
                if (!fpga_start) begin
                    state_d    = IDLE;
                    clear_mask = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Register bank updates: operand capture, sticky flags, result
    always_comb begin
        opa_d     = opa_q;
        opb_d     = opb_q;
        opcode_d  = opcode_q;
        mask_d    = mask_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        result_d  = result_q;

        if (accept_ops) begin
            if (hit_opa) begin
                opa_d            = fpga_wdata;
                mask_d[MASK_OPA] = 1'b1;
            end
            if (hit_opb) begin
                opb_d            = fpga_wdata;
                mask_d[MASK_OPB] = 1'b1;
            end
            if (hit_opcode) begin
                opcode_d            = fpga_wdata[3:0];
                mask_d[MASK_OPCODE] = 1'b1;
            end
        end
        if (clear_mask) begin
            mask_d = '0;
        end

        // Clears first so a same-cycle new event still leaves its flag set
        if (clr_sticky || enter_run) begin
            timeout_d = 1'b0;
        end
        if (clr_sticky) begin
            overrun_d = 1'b0;
        end
        if (!accept_ops && fpga_op_wr) begin
            overrun_d = 1'b1;
        end
        if (set_timeout) begin
            timeout_d = 1'b1;
        end

        if (wr_result) begin
            result_d = cpu_wdata;
        end
    end

    // Register bank storage
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            opa_q     <= '0;
            opb_q     <= '0;
            opcode_q  <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            result_q  <= '0;
            start_q   <= 1'b0;
        end else begin
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            opcode_q  <= opcode_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            result_q  <= result_d;
            start_q   <= fpga_start;
        end
    end

    // STATUS word and CPU read mux
    always_comb begin
        status                             = '0;
        status[ST_BUSY]                    = (state_q == RUN);
        status[ST_DONE]                    = (state_q == DONE);
        status[ST_TIMEOUT]                 = timeout_q;
        status[ST_OVERRUN]                 = overrun_q;
        status[ST_BAD_OP]                  = !opcode_valid(opcode_q);
        status[ST_MASK_LSB+2:ST_MASK_LSB]  = mask_q;

        rdata_d = rdata_q;
        if (cpu_re) begin
            case (cpu_addr)
                A_OPA:    rdata_d = opa_q;
                A_OPB:    rdata_d = opb_q;
                A_OPCODE: rdata_d = {28'd0, opcode_q};
                A_STATUS: rdata_d = status;
                A_RESULT: rdata_d = result_q;
                A_CTRL:   rdata_d = '0;
                A_DUMP:   rdata_d = '0;
                default:  rdata_d = '0;
            endcase
        end
    end

    // Registered load response
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= cpu_re;
        end
    end

    assign cpu_rdata    = rdata_q;
    assign cpu_rvalid   = rvalid_q;
    assign cpu_run      = (state_q == RUN);
    assign result       = result_q;
    assign result_valid = (state_q == DONE);

endmodule

// File: tb/tb_calc_mailbox.sv
// Self-checking bench for calc_mailbox: a behavioural model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_calc_mailbox;

    localparam int TO = 5;

    logic        hz100 = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fpga_addr = '0, fpga_wdata = '0;
    logic        fpga_we = 1'b0, fpga_start = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_we = 1'b0, cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid, cpu_run;
    logic [31:0] result;
    logic        result_valid;

    int n_chk = 0;
    int n_pass = 0;

    calc_mailbox #(
        .BASE_ADDR      (32'd220),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .hz100        (hz100),
        .reset        (reset),
        .fpga_addr    (fpga_addr),
        .fpga_wdata   (fpga_wdata),
        .fpga_we      (fpga_we),
        .fpga_start   (fpga_start),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_rdata    (cpu_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_run      (cpu_run),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 hz100 = ~hz100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                     nm, act, act, exp, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
    int          m_phase;
    logic [31:0] m_opa, m_opb, m_result, m_rdata;
    logic [3:0]  m_opc;
    bit          m_wa, m_wb, m_wc, m_to, m_ovr, m_rvalid, m_prev_start;
    int          m_tcnt;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = 32'd0;
        s[0] = (m_phase == P_RUN);
        s[1] = (m_phase == P_DONE);
        s[2] = m_to;
        s[3] = m_ovr;
        s[4] = ($countones(m_opc) != 1);
        s[5] = m_wa;
        s[6] = m_wb;
        s[7] = m_wc;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            32'd220: return m_opa;
            32'd224: return m_opb;
            32'd228: return {28'd0, m_opc};
            32'd232: return m_status();
            32'd236: return m_result;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge hz100 or negedge reset) begin
        bit open, all_w, rise, done_req, ovr_set;
        if (!reset) begin
            m_phase = P_IDLE; m_opa = 0; m_opb = 0; m_opc = 0; m_result = 0;
            m_rdata = 0; m_wa = 0; m_wb = 0; m_wc = 0; m_to = 0; m_ovr = 0;
            m_rvalid = 0; m_prev_start = 0; m_tcnt = 0;
        end else begin
            if (cpu_re) m_rdata = m_read(cpu_addr);
            m_rvalid = cpu_re;
            open     = (m_phase == P_IDLE) || (m_phase == P_ARMED);
            all_w    = m_wa && m_wb && m_wc;
            rise     = fpga_start && !m_prev_start;
            m_prev_start = fpga_start;
            done_req = cpu_we && cpu_addr == 32'd240 && cpu_wdata[0];
            ovr_set  = 0;
            if (fpga_we && (fpga_addr == 220 || fpga_addr == 224 || fpga_addr == 228)) begin
                if (!open) ovr_set = 1;
                else if (fpga_addr == 220) begin m_opa = fpga_wdata; m_wa = 1; end
                else if (fpga_addr == 224) begin m_opb = fpga_wdata; m_wb = 1; end
                else begin m_opc = fpga_wdata[3:0]; m_wc = 1; end
            end
            if (cpu_we && cpu_addr == 32'd236) m_result = cpu_wdata;
            if (cpu_we && cpu_addr == 32'd240 && cpu_wdata[1]) begin m_ovr = 0; m_to = 0; end
            if (ovr_set) m_ovr = 1;
            case (m_phase)
                P_IDLE:  if (all_w) m_phase = P_ARMED;
                P_ARMED: if (rise) begin m_phase = P_RUN; m_to = 0; m_tcnt = 0; end
                P_RUN: begin
                    if (done_req) m_phase = P_DONE;
`ifdef CALC_MAILBOX_TIMEOUT_EN
                    else if (m_tcnt == TO - 1) begin m_phase = P_DONE; m_to = 1; end
                    else m_tcnt++;
`endif
                end
                default: if (!fpga_start) begin m_phase = P_IDLE; m_wa = 0; m_wb = 0; m_wc = 0; end
            endcase
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge hz100) begin
        chk("m_cpu_run", {31'd0, cpu_run}, {31'd0, m_phase == P_RUN});
        chk("m_result_valid", {31'd0, result_valid}, {31'd0, m_phase == P_DONE});
        chk("m_result", result, m_result);
        chk("m_rvalid", {31'd0, cpu_rvalid}, {31'd0, m_rvalid});
        chk("m_rdata", cpu_rdata, m_rdata);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge hz100);
    endtask

    task automatic fpga_wr(input logic [31:0] a, input logic [31:0] d);
        fpga_addr = a; fpga_wdata = d; fpga_we = 1'b1;
        tick();
        fpga_we = 1'b0;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic cpu_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        cpu_addr = a; cpu_re = 1'b1;
        tick();
        cpu_re = 1'b0;
        chk(nm, cpu_rdata, exp);
        chk({nm, "_rvalid"}, {31'd0, cpu_rvalid}, 32'd1);
    endtask

    initial begin
        tick(); tick();
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_run", {31'd0, cpu_run}, 0);
        chk("rst_result", result, 0);
        chk("rst_rvalid", {31'd0, cpu_rvalid}, 0);
        reset = 1'b1;
        tick();

        // Full handshake with an overrun in RUN
        fpga_wr(220, 12);
        fpga_wr(224, 7);
        fpga_wr(228, 32'h8);
        tick();
        fpga_start = 1'b1;
        tick();
        chk("run_after_start", {31'd0, cpu_run}, 1);
        cpu_rd("rd_opa", 220, 12);
        cpu_rd("rd_opb", 224, 7);
        cpu_rd("rd_opc", 228, 8);
        cpu_rd("st_run", 232, 32'hE1);
        fpga_wr(224, 99);
        cpu_rd("rd_opb_kept", 224, 7);
        cpu_rd("st_overrun", 232, 32'hE9);
        cpu_wr(236, 19);
        chk("result19", result, 19);
        chk("not_done_yet", {31'd0, result_valid}, 0);
        cpu_wr(240, 1);
        chk("done_valid", {31'd0, result_valid}, 1);
        chk("done_run_low", {31'd0, cpu_run}, 0);
        cpu_rd("st_done", 232, 32'hEA);
        cpu_wr(240, 2);
        cpu_rd("st_cleared", 232, 32'hE2);
        fpga_start = 1'b0;
        tick();
        chk("idle_valid", {31'd0, result_valid}, 0);
        chk("idle_result", result, 19);
        cpu_rd("st_idle", 232, 0);

        // Incomplete load: start pulse ignored
        fpga_wr(220, 5);
        fpga_wr(224, 6);
        fpga_start = 1'b1;
        tick();
        fpga_start = 1'b0;
        tick(); tick();
        chk("incomplete_run", {31'd0, cpu_run}, 0);
        cpu_rd("st_partial", 232, 32'h60);

        // Simultaneous FPGA opcode write and CPU result write; bad opcode
        fpga_addr = 228; fpga_wdata = 6; fpga_we = 1'b1;
        cpu_addr = 236; cpu_wdata = 77; cpu_we = 1'b1;
        tick();
        fpga_we = 1'b0; cpu_we = 1'b0;
        chk("simul_result", result, 77);
        tick();
        cpu_rd("st_badop", 232, 32'hF0);
        cpu_rd("rd_opc6", 228, 6);
        cpu_rd("rd_opa5", 220, 5);
        cpu_rd("rd_dump", 244, 0);
        cpu_rd("rd_unmapped", 32'h100, 0);
        tick();
        chk("rvalid_drop", {31'd0, cpu_rvalid}, 0);

        // Enter RUN, then asynchronous reset between edges
        fpga_start = 1'b1;
        tick();
        chk("run2", {31'd0, cpu_run}, 1);
`ifndef CALC_MAILBOX_TIMEOUT_EN
        repeat (8) tick();
        chk("run_no_timeout", {31'd0, cpu_run}, 1);
        cpu_rd("st_run_wait", 232, 32'hF1);
`endif
        cpu_rd("rd_before_rst", 220, 5);
        #2 reset = 1'b0;
        #1;
        chk("arst_run", {31'd0, cpu_run}, 0);
        chk("arst_result", result, 0);
        chk("arst_valid", {31'd0, result_valid}, 0);
        chk("arst_rvalid", {31'd0, cpu_rvalid}, 0);
        chk("arst_rdata", cpu_rdata, 0);
        tick();
        fpga_start = 1'b0;
        reset = 1'b1;
        tick();
        cpu_rd("st_after_rst", 232, 32'h10);
        cpu_rd("opa_after_rst", 220, 0);

`ifdef CALC_MAILBOX_TIMEOUT_EN
        begin
            int n_run;
            n_run = 0;
            cpu_wr(236, 33);
            fpga_wr(220, 1);
            fpga_wr(224, 2);
            fpga_wr(228, 32'h2);
            tick();
            fpga_start = 1'b1;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (result_valid) break;
                if (cpu_run) n_run++;
            end
            chk("to_valid", {31'd0, result_valid}, 1);
            chk("to_cycles", n_run, TO);
            chk("to_result", result, 33);
            cpu_rd("st_timeout", 232, 32'hE6);
            cpu_wr(240, 2);
            cpu_rd("st_to_clear", 232, 32'hE2);
            fpga_start = 1'b0;
            tick();
        end
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/calc_mailbox.md
# calc_mailbox

CPU-side responder for the calculator front-end's memory-mapped handoff. It captures the front-end's operand and opcode writes into a register bank, exposes them to the single-cycle CPU over a simple load/store port, and sequences the run and done handshake. When the CPU posts its result, the block returns it to the front-end for seven-segment display.

## Interface
Parameters:
- BASE_ADDR, 32'd220: byte address of operand A. All other registers sit at fixed offsets from it.
- TIMEOUT_CYCLES, 200: RUN-state cycle limit. Used only when the timeout feature is compiled in.

Ports:
- hz100  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- fpga_addr  in  32  front-end write address.
- fpga_wdata  in  32  front-end write data.
- fpga_we  in  1  front-end write strobe, sampled each cycle.
- fpga_start  in  1  front-end level request to compute.
- cpu_addr  in  32  CPU load/store address.
- cpu_wdata  in  32  CPU store data.
- cpu_we  in  1  CPU store strobe.
- cpu_re  in  1  CPU load strobe.
- cpu_rdata  out  32  registered load data.
- cpu_rvalid  out  1  high for the cycle after a load is accepted.
- cpu_run  out  1  tells the CPU program that operands are ready (high in RUN).
- result  out  32  last result posted by the CPU, driven to the display.
- result_valid  out  1  high in DONE.

## Operation
- Register map, byte offsets from BASE_ADDR:
  - +0 (220): OPA, front-end writes it.
  - +4 (224): OPB, front-end writes it.
  - +8 (228): OPCODE, front-end writes it; bits [3:0] are stored.
  - +12 (232): STATUS, read-only.
  - +16 (236): RESULT, CPU writes it.
  - +20 (240): CTRL, CPU writes it.
  - +24 (244): dump address; writes are ignored and reads return 0.
- Address decode is a full 32-bit compare. Unmapped reads return 0. Unmapped writes are dropped.
- Opcodes are one-hot: 4'b1000 add, 4'b0100 sub, 4'b0010 mul, 4'b0001 div.
- STATUS bits:
  - [0] busy, set in RUN.
  - [1] done, set in DONE.
  - [2] timeout, sticky.
  - [3] overrun, sticky.
  - [4] bad_op: the stored opcode is not one-hot (combinational).
  - [7:5] written mask for {OPCODE, OPB, OPA}.
  - All other bits read 0.
- States and transitions:
  - IDLE: stays in IDLE until all three mask bits are set, then goes to ARMED.
  - ARMED: a rising edge of fpga_start moves to RUN and clears the timeout bit.
  - RUN: a CPU write to CTRL with wdata[0]=1 moves to DONE.
  - DONE: fpga_start low moves to IDLE and clears the mask.
- Front-end writes to OPA, OPB or OPCODE:
  - Accepted in IDLE or ARMED; the new value overwrites the old one.
  - In RUN or DONE the write is dropped and overrun is set.
- CPU stores:
  - A write to RESULT updates the result register in any state.
  - A write to CTRL with wdata[1]=1 clears the sticky bits [3:2].
- Simultaneous events:
  - FPGA and CPU writes in the same cycle are both honoured, since they target disjoint registers.
  - A CTRL write that both sets done and clears sticky bits does both.
  - A rising edge of fpga_start in IDLE (mask incomplete) is ignored and is not remembered.

## Timing
- Reset values:
  - cpu_rdata = 0, cpu_rvalid = 0, cpu_run = 0, result = 0, result_valid = 0.
  - State = IDLE; OPA, OPB, OPCODE, mask and sticky bits all 0.
- Reset asserted mid-operation returns the block to IDLE at once, asynchronously.
- Start edge detection uses a one-cycle registered copy of fpga_start. RUN is entered on the edge after the rise is seen, so cpu_run rises 1 cycle after the first high sample.
- Loads: cpu_re in cycle N gives cpu_rdata and cpu_rvalid=1 in cycle N+1. The data reflects register values before edge N.
- result_valid rises on the edge that captures the CTRL done write.
- result updates on the edge that captures the RESULT write.

## Configuration
- Macro: CALC_MAILBOX_TIMEOUT_EN.
- Defined:
  - A counter runs in RUN.
  - When it reaches TIMEOUT_CYCLES-1 with no done write, the block enters DONE, sets the timeout bit and leaves result unchanged.
  - A done write in the same cycle takes priority and does not set timeout.
- Undefined:
  - There is no counter.
  - RUN waits indefinitely and STATUS[2] reads 0.

## Structure
- Shared package calc_mailbox_pkg holds:
  - The state enum {IDLE, ARMED, RUN, DONE}.
  - The register offset localparams.
  - The one-hot opcode constants.
  - The STATUS bit index constants.
- One sub-module, calc_mailbox_timer, holds the RUN counter and the expiry flag. It is instantiated only under CALC_MAILBOX_TIMEOUT_EN.

## Test plan
- Full handshake:
  - Stimulus: FPGA writes 220←12, 224←7, 228←4'b1000, then raises fpga_start. CPU reads 220/224/228, writes 236←19, then writes 240←1.
  - Required: reads return 12/7/8, cpu_run=1 during RUN, then result=19 with result_valid=1. Dropping fpga_start returns the block to IDLE.
- Overrun:
  - Stimulus: FPGA writes 224←99 while in RUN.
  - Required: OPB keeps its old value; STATUS[3]=1 until the CPU writes 240←2.
- Incomplete load:
  - Stimulus: write OPA and OPB only, then pulse fpga_start.
  - Required: state stays IDLE, cpu_run=0, STATUS[7:5]=3'b011.
- Bad opcode and unmapped access:
  - Stimulus: OPCODE←4'b0110; read 244 and 0x100.
  - Required: STATUS[4]=1; both reads return 0 with cpu_rvalid pulsing one cycle.
- Timeout, with the macro defined and TIMEOUT_CYCLES=5:
  - Stimulus: enter RUN and issue no CTRL write.
  - Required: DONE after 5 cycles, STATUS[2]=1, result unchanged.
- Asynchronous reset:
  - Stimulus: assert reset low mid-RUN, between clock edges.
  - Required: all outputs go to 0 and state goes to IDLE immediately.
